// File: rtl/javk_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : javk_bus_ctrl
// Description : Core-to-external 8-bit bus controller. Splits 8/16-bit core
//               accesses into byte cycles, inserts wait states on ready=0 and
//               aborts with err after WAIT_MAX consecutive wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module javk_bus_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        wide,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    input  logic        ready,
    output logic [15:0] addrbus,
    output logic        rw,
    inout  wire  [7:0]  databus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] c_WAIT_MAX = 8'(WAIT_MAX);

    state_t      r_state;
    state_t      w_next;

    // Access attributes latched at acceptance; core inputs are ignored afterwards
    logic        r_we;
    logic        r_wide;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic [7:0]  r_wait;
    logic [7:0]  r_rlo;
    logic [15:0] r_rdata;
    logic [15:0] r_addrbus;
    logic        r_rw;
    logic        r_oe;
    logic [7:0]  r_dout;
    logic        r_err;

    logic        w_timeout;
    logic [15:0] w_addr_hi;

    // The wait counter has already reached the limit and the bus is still not ready
    assign w_timeout = !ready && (r_wait == c_WAIT_MAX);
    // Second byte address wraps naturally at 16 bits
    assign w_addr_hi = r_addr + 16'd1;

    assign databus = r_oe ? r_dout : 8'hzz;
    assign ack     = (r_state == S_DONE);
    assign err     = r_err;
    assign rdata   = r_rdata;
    assign addrbus = r_addrbus;
    assign rw      = r_rw;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req) w_next = S_LO;
            S_LO: begin
                if (ready)          w_next = r_wide ? S_HI : S_DONE;
                else if (w_timeout) w_next = S_DONE;
            end
            S_HI:   if (ready || w_timeout) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: request latch, bus drivers, wait counter and read assembly.
    // rdata is only updated when a read finishes so it holds across writes and
    // in-flight reads; the low byte of a 16-bit read is staged in r_rlo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we      <= 1'b0;
            r_wide    <= 1'b0;
            r_addr    <= 16'h0000;
            r_wdata   <= 16'h0000;
            r_wait    <= 8'h00;
            r_rlo     <= 8'h00;
            r_rdata   <= 16'h0000;
            r_addrbus <= 16'h0000;
            r_rw      <= 1'b1;
            r_oe      <= 1'b0;
            r_dout    <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we      <= we;
                        r_wide    <= wide;
                        r_addr    <= addr;
                        r_wdata   <= wdata;
                        r_addrbus <= addr;
                        r_rw      <= ~we;
                        r_oe      <= we;
                        r_dout    <= wdata[7:0];
                        r_wait    <= 8'h00;
                        r_rlo     <= 8'h00;
                    end
                end
                S_LO: begin
                    if (ready) begin
                        r_wait <= 8'h00;
                        if (r_wide) begin
                            r_rlo     <= databus;
                            r_addrbus <= w_addr_hi;
                            r_dout    <= r_wdata[15:8];
                        end else begin
                            r_rw <= 1'b1;
                            r_oe <= 1'b0;
                            if (!r_we) r_rdata <= {8'h00, databus};
                        end
                    end else if (w_timeout) begin
                        r_rw  <= 1'b1;
                        r_oe  <= 1'b0;
                        r_err <= 1'b1;
                        if (!r_we) r_rdata <= 16'h0000;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_HI: begin
                    if (ready) begin
                        r_rw <= 1'b1;
                        r_oe <= 1'b0;
                        if (!r_we) r_rdata <= {databus, r_rlo};
                    end else if (w_timeout) begin
                        r_rw  <= 1'b1;
                        r_oe  <= 1'b0;
                        r_err <= 1'b1;
                        if (!r_we) r_rdata <= {8'h00, r_rlo};
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_DONE: begin
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_javk_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_javk_bus_ctrl
// Description : Self-checking bench for javk_bus_ctrl with a scoreboard of
//               expected completions and a cycle-by-cycle bus expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_javk_bus_ctrl;

    localparam int         WMAX     = 4;
    localparam logic [7:0] IDLE_PAT = 8'hC3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        wide = 1'b0;
    logic        ready = 1'b1;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [7:0]  tb_bus = IDLE_PAT;
    wire  [15:0] rdata;
    wire         ack;
    wire         err;
    wire  [15:0] addrbus;
    wire         rw;
    wire  [7:0]  databus;

    // External device drives the bus whenever the controller signals read/idle
    assign databus = rw ? tb_bus : 8'hzz;

    javk_bus_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .wide    (wide),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .err     (err),
        .ready   (ready),
        .addrbus (addrbus),
        .rw      (rw),
        .databus (databus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_rdata  = 16'h0000;

    // One access: build the expected bus cycles, push the completion, drive and check
    task automatic do_access(input logic w, input logic wd, input logic [15:0] a,
                             input logic [15:0] d, input logic [7:0] rb0,
                             input logic [7:0] rb1, input int wl, input int wh,
                             input string nm);
        logic [15:0] e_addr [0:31];
        logic        e_rdy  [0:31];
        logic [7:0]  e_bus  [0:31];
        logic [7:0]  rb [2];
        logic [7:0]  wb [2];
        bit          cap [2];
        int          n;
        logic        e_err;
        exp_t        e;
        exp_t        g;
        bit          seen;
        logic [15:0] last_a;
        rb[0] = rb0; rb[1] = rb1; wb[0] = d[7:0]; wb[1] = d[15:8];
        cap[0] = 0; cap[1] = 0; n = 1; e_err = 1'b0;
        for (int b = 0; b < (wd ? 2 : 1); b++) begin
            int          wt;
            int          nw;
            logic [15:0] ab;
            wt = (b == 0) ? wl : wh;
            ab = a + 16'(b);
            nw = (wt > WMAX) ? WMAX + 1 : wt;
            for (int k = 0; k < nw; k++) begin
                e_addr[n] = ab; e_rdy[n] = 1'b0; e_bus[n] = w ? wb[b] : rb[b]; n++;
            end
            if (wt > WMAX) begin
                e_err = 1'b1;
                break;
            end
            e_addr[n] = ab; e_rdy[n] = 1'b1; e_bus[n] = w ? wb[b] : rb[b]; n++;
            cap[b] = 1;
        end
        if (!w) m_rdata = {cap[1] ? rb[1] : 8'h00, cap[0] ? rb[0] : 8'h00};
        e.lat = n; e.err = e_err; e.rdata = m_rdata;
        sb.push_back(e);
        last_a = e_addr[n-1];

        @(negedge clk);
        req = 1'b1; we = w; wide = wd; addr = a; wdata = d; ready = 1'b1; tb_bus = IDLE_PAT;
        seen = 0;
        for (int cyc = 1; cyc <= n + 4 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                req = 1'b0; we = 1'($urandom); wide = 1'($urandom);
                addr = 16'($urandom); wdata = 16'($urandom);
            end
            tb_bus = (cyc < n) ? e_bus[cyc] : IDLE_PAT;
            ready  = (cyc < n) ? e_rdy[cyc] : 1'b1;
            #1;
            if (ack) begin
                seen = 1;
                g = sb.pop_front();
                n_checks++;
                if (cyc != g.lat) begin
                    n_fail++;
                    $display("FAIL %s ack_latency got=%0d exp=%0d", nm, cyc, g.lat);
                end
                n_checks++;
                if ({err, rdata} !== {g.err, g.rdata}) begin
                    n_fail++;
                    $display("FAIL %s err_rdata got=%b/%h exp=%b/%h", nm, err, rdata, g.err, g.rdata);
                end
                n_checks++;
                if ({rw, databus} !== {1'b1, IDLE_PAT}) begin
                    n_fail++;
                    $display("FAIL %s done_bus rw/data got=%b/%h exp=1/%h", nm, rw, databus, IDLE_PAT);
                end
            end else if (cyc < n) begin
                n_checks++;
                if ({addrbus, rw, ack, databus} !== {e_addr[cyc], ~w, 1'b0, e_bus[cyc]}) begin
                    n_fail++;
                    $display("FAIL %s bus_cyc%0d got addr=%h rw=%b ack=%b data=%h exp addr=%h rw=%b ack=0 data=%h",
                             nm, cyc, addrbus, rw, ack, databus, e_addr[cyc], ~w, e_bus[cyc]);
                end
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL %s no_ack got=none exp=ack_at_%0d", nm, n);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({ack, err, rw, addrbus} !== {1'b0, 1'b0, 1'b1, last_a}) begin
            n_fail++;
            $display("FAIL %s idle_after got ack=%b err=%b rw=%b addr=%h exp 0/0/1/%h",
                     nm, ack, err, rw, addrbus, last_a);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({addrbus, rw, rdata, ack, err} !== {16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got addr=%h rw=%b rdata=%h ack=%b err=%b exp 0000/1/0000/0/0",
                     addrbus, rw, rdata, ack, err);
        end
        n_checks++;
        if (databus !== IDLE_PAT) begin
            n_fail++;
            $display("FAIL reset_databus got=%h exp=%h", databus, IDLE_PAT);
        end
        repeat (3) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({ack, rw, addrbus} !== {1'b0, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_hold got ack=%b rw=%b addr=%h exp 0/1/0000", ack, rw, addrbus);
        end
        req = 1'b0;
        m_rdata = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read8();
        do_access(1'b0, 1'b0, 16'h1234, 16'h0000, 8'hA5, 8'h00, 0, 0, "read8");
    endtask

    task automatic test_write();
        do_access(1'b1, 1'b1, 16'h2000, 16'hBEEF, 8'h00, 8'h00, 0, 0, "write16");
        do_access(1'b1, 1'b0, 16'h0010, 16'h1234, 8'h00, 8'h00, 0, 0, "write8");
    endtask

    task automatic test_wrap();
        do_access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h11, 8'h22, 0, 0, "wrap16");
    endtask

    task automatic test_wait();
        do_access(1'b0, 1'b0, 16'h0100, 16'h0000, 8'h3D, 8'h00, 3, 0, "wait3");
        do_access(1'b1, 1'b1, 16'h0200, 16'hA55A, 8'h00, 8'h00, WMAX, WMAX, "wait_max_write");
        do_access(1'b0, 1'b1, 16'h0300, 16'h0000, 8'h81, 8'h7E, 2, WMAX, "wait_max_read");
    endtask

    task automatic test_timeout();
        do_access(1'b0, 1'b1, 16'h5000, 16'h0000, 8'h5A, 8'hEE, 0, 99, "timeout_hi");
        do_access(1'b0, 1'b0, 16'h6000, 16'h0000, 8'h44, 8'h00, WMAX + 1, 0, "timeout_lo");
        do_access(1'b1, 1'b1, 16'h7000, 16'h1357, 8'h00, 8'h00, 0, 99, "timeout_write");
    endtask

    // req held high: the DONE cycle must not accept, the following IDLE cycle must
    task automatic test_back_to_back();
        exp_t e;
        exp_t g;
        m_rdata = 16'h0077;
        e.lat = 2; e.err = 1'b0; e.rdata = 16'h0077; sb.push_back(e);
        e.lat = 5; sb.push_back(e);
        @(negedge clk);
        req = 1'b1; we = 1'b0; wide = 1'b0; addr = 16'h4000; ready = 1'b1; tb_bus = 8'h77;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc == 4) req = 1'b0;
            #1;
            if (ack) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b extra_ack got=ack_at_%0d exp=none", cyc);
                end else begin
                    g = sb.pop_front();
                    if ({cyc, rdata} !== {g.lat, g.rdata}) begin
                        n_fail++;
                        $display("FAIL b2b ack got cyc=%0d rdata=%h exp cyc=%0d rdata=%h",
                                 cyc, rdata, g.lat, g.rdata);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b missing_acks got=%0d_left exp=0", sb.size());
            sb.delete();
        end
        tb_bus = IDLE_PAT;
    endtask

    // Asynchronous reset while the high byte of a write is on the bus
    task automatic test_reset_mid();
        @(negedge clk);
        req = 1'b1; we = 1'b1; wide = 1'b1; addr = 16'h3000; wdata = 16'hCAFE; ready = 1'b1;
        tb_bus = IDLE_PAT;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({addrbus, rw, databus} !== {16'h3001, 1'b0, 8'hCA}) begin
            n_fail++;
            $display("FAIL rstmid_hi got addr=%h rw=%b data=%h exp 3001/0/ca", addrbus, rw, databus);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({addrbus, rw, ack, err, rdata, databus} !== {16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, IDLE_PAT}) begin
            n_fail++;
            $display("FAIL rstmid_async got addr=%h rw=%b ack=%b err=%b rdata=%h data=%h exp 0000/1/0/0/0000/%h",
                     addrbus, rw, ack, err, rdata, databus, IDLE_PAT);
        end
        m_rdata = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (ack !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_noack got=%b exp=0", ack);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        do_access(1'b0, 1'b0, 16'h0042, 16'h0000, 8'h99, 8'h00, 1, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_read8();
        test_write();
        test_wrap();
        test_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
